sram_request_handler: RTL and testbench
=======================================

Name: sram_request_handler

Overview:
Single-port SRAM arbiter that sits directly upstream of the VGA output stage. It serves the VGA pixel-word fetches (data_en / word_address_dest / VGA_state) and the CPU data-bus accesses to one shared SRAM port. It keeps a one-word VGA fetch buffer, so repeated reads of the same word return with no wait. It blocks the CPU during the VGA pre-active and active windows so that pixel fetches are never starved.

Parameters:
READ_LATENCY, 2, number of cycles the SRAM strobes are held per access before sram_rdata is sampled; legal range 1..15
ADDR_W, 32, word address width on every address port

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
vga_state  in  2  VGA phase: 0 = inactive, 1 = about to be active, 2 = active; 3 is treated as 0
vga_req  in  1  VGA fetch request (the VGA stage's data_en)
vga_addr  in  ADDR_W  VGA word address
vga_data  out  32  buffered VGA word
vga_busy  out  1  VGA word not yet valid for vga_addr
cpu_ren  in  1  CPU read request
cpu_wen  in  1  CPU write request
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  32  CPU write data
cpu_sel  in  4  CPU byte select
cpu_rdata  out  32  CPU read data
cpu_busy  out  1  CPU access in progress or stalled
sram_addr  out  ADDR_W  SRAM word address
sram_wdata  out  32  SRAM write data
sram_sel  out  4  SRAM byte select
sram_ren  out  1  SRAM read strobe
sram_wen  out  1  SRAM write strobe
sram_rdata  in  32  SRAM read data

Behaviour:
- Reset (async, nrst low):
  - FSM goes to IDLE.
  - Registers cleared: vga_data, cpu_rdata, buffer address, buffer valid, latency counter, cpu_done.
  - All sram_* outputs are 0 immediately; a transfer in flight is abandoned.
  - vga_busy and cpu_busy follow their combinational equations with buffer invalid.
- FSM states: IDLE, CPU_ACC, VGA_ACC.
- VGA hit: hit = buf_valid & (vga_addr == buf_addr).
  - vga_busy = vga_req & ~hit, combinational.
  - vga_data always drives the buffered word.
- CPU blocking: cpu_busy = (cpu_ren | cpu_wen) & ~cpu_done, combinational.
  - cpu_done is a registered one-cycle pulse.
  - The CPU must drop its request in the cycle cpu_done is seen.
  - If the CPU holds the request after cpu_done, that is a new access.
- IDLE grant priority, evaluated each cycle, first match wins:
  - (1) vga_req & ~hit: latch vga_addr and go to VGA_ACC.
  - (2) cpu_ren|cpu_wen, vga_state==0, ~cpu_done: latch addr/wdata/sel and go to CPU_ACC. cpu_wen overrides cpu_ren, so a write is performed.
  - (3) Otherwise stay in IDLE.
  - A CPU request with vga_state != 0 is stalled (cpu_busy high) with no timeout.
- CPU_ACC / VGA_ACC:
  - Counter loads READ_LATENCY-1 on entry.
  - sram_addr, sram_sel, sram_wdata and the strobe are held stable for exactly READ_LATENCY cycles.
  - VGA accesses use sram_sel = 4'hF and sram_ren only.
  - In the last cycle (counter==0):
    - CPU read: sram_rdata is registered into cpu_rdata.
    - VGA access: sram_rdata goes into vga_data, buf_addr is set to the latched address, and buf_valid is set.
    - FSM returns to IDLE; cpu_done is set for CPU accesses.
  - Strobes drop in the IDLE cycle that follows; there is no back-to-back issue.
  - CPU request latency from first asserted cycle T, with no contention: cpu_busy is high on cycles T..T+READ_LATENCY and low at T+READ_LATENCY+1 with cpu_rdata valid.
  - VGA miss latency is identical; vga_busy drops at T+READ_LATENCY+1.
- VGA request during CPU_ACC: the CPU access completes, then the VGA request wins the next IDLE.
- A vga_addr change mid VGA_ACC does not abort the access; the miss re-evaluates in IDLE.
- Buffer invalidation:
  - buf_valid clears on the cycle vga_state changes 0 to 1 (new frame).
  - buf_valid clears on completion of a CPU write whose address equals buf_addr.
  - If invalidation and a VGA fill complete in the same cycle, the fill wins.
- Address compare uses the full ADDR_W bits; there is no wrap arithmetic in the block.

Test Plan:
1. READ_LATENCY=2, vga_state=0, cpu_ren at cycle 1 with addr 0x10, sram_rdata=0xDEADBEEF -> sram_ren high cycles 2-3; cpu_busy high cycles 1-3; cpu_done at cycle 4 with cpu_rdata=0xDEADBEEF.
2. vga_state=2, vga_req with addr 0x3E80 (miss) -> one SRAM read; vga_busy low after 3 cycles; vga_data = the SRAM word. Hold the same addr for 20 cycles -> no further sram_ren, vga_busy=0.
3. vga_state=1 with cpu_wen pending -> cpu_busy stays high and sram_wen=0 until vga_state returns to 0; then the write issues with the given sel/wdata.
4. CPU read in CPU_ACC when vga_req (miss) arrives -> CPU finishes first, then VGA_ACC starts in the following IDLE+1 cycle; vga_busy is high throughout.
5. Buffer valid at 0x3E81; CPU write to 0x3E81 completes -> next vga_req 0x3E81 misses and re-reads. Also: vga_state 0 to 1 -> next request misses.
6. Assert nrst low mid VGA_ACC -> sram_ren drops asynchronously and buf_valid=0. After release, the same vga_req misses and re-fetches.

Source files
------------

// File: rtl/sram_request_handler.sv
// Single-port SRAM arbiter between VGA pixel-word fetches and CPU data-bus accesses.
// Holds a one-word VGA buffer and stalls the CPU while the VGA stage is (about to be) active.
module sram_request_handler #(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [1:0]        vga_state,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [31:0]       vga_data,
   output logic              vga_busy,
   input  logic              cpu_ren,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_sel,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   output logic [3:0]        sram_sel,
   output logic              sram_ren,
   output logic              sram_wen,
   input  logic [31:0]       sram_rdata
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;

   typedef enum logic [1:0] {IDLE, CPU_ACC, VGA_ACC} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [ADDR_W-1:0]   buf_addr, buf_addr_nxt;
   logic                buf_valid, buf_valid_nxt;
   logic                cpu_done, cpu_done_nxt;
   logic [1:0]          vga_phase, vga_phase_q;
   logic [DATA_W-1:0]   vga_data_nxt, cpu_rdata_nxt;
   logic [ADDR_W-1:0]   sram_addr_nxt;
   logic [DATA_W-1:0]   sram_wdata_nxt;
   logic [SEL_W-1:0]    sram_sel_nxt;
   logic                sram_ren_nxt, sram_wen_nxt;
   logic                hit, cpu_req, frame_start;

   // Phase 3 behaves as inactive
   assign vga_phase   = (vga_state == 2'd3) ? 2'd0 : vga_state;
   assign frame_start = (vga_phase == 2'd1) && (vga_phase_q == 2'd0);
   assign hit         = buf_valid & (vga_addr == buf_addr);
   assign cpu_req     = cpu_ren | cpu_wen;
   assign vga_busy    = vga_req & ~hit;
   assign cpu_busy    = cpu_req & ~cpu_done;

   // State and datapath registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         cnt         <= '0;
         buf_addr    <= '0;
         buf_valid   <= 1'b0;
         cpu_done    <= 1'b0;
         vga_phase_q <= 2'd0;
         vga_data    <= '0;
         cpu_rdata   <= '0;
         sram_addr   <= '0;
         sram_wdata  <= '0;
         sram_sel    <= '0;
         sram_ren    <= 1'b0;
         sram_wen    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         buf_addr    <= buf_addr_nxt;
         buf_valid   <= buf_valid_nxt;
         cpu_done    <= cpu_done_nxt;
         vga_phase_q <= vga_phase;
         vga_data    <= vga_data_nxt;
         cpu_rdata   <= cpu_rdata_nxt;
         sram_addr   <= sram_addr_nxt;
         sram_wdata  <= sram_wdata_nxt;
         sram_sel    <= sram_sel_nxt;
         sram_ren    <= sram_ren_nxt;
         sram_wen    <= sram_wen_nxt;
      end
   end

   // Grant, access sequencing and buffer maintenance
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      buf_addr_nxt   = buf_addr;
      buf_valid_nxt  = frame_start ? 1'b0 : buf_valid;
      cpu_done_nxt   = 1'b0;
      vga_data_nxt   = vga_data;
      cpu_rdata_nxt  = cpu_rdata;
      sram_addr_nxt  = sram_addr;
      sram_wdata_nxt = sram_wdata;
      sram_sel_nxt   = sram_sel;
      sram_ren_nxt   = sram_ren;
      sram_wen_nxt   = sram_wen;

      case (state)
         IDLE: begin
            if (vga_busy) begin
               state_nxt      = VGA_ACC;
               cnt_nxt        = CNT_W'(READ_LATENCY - 1);
               sram_addr_nxt  = vga_addr;
               sram_wdata_nxt = '0;
               sram_sel_nxt   = SEL_W'(4'hF);
               sram_ren_nxt   = 1'b1;
               sram_wen_nxt   = 1'b0;
            end else if (cpu_req && (vga_phase == 2'd0) && !cpu_done) begin
               state_nxt      = CPU_ACC;
               cnt_nxt        = CNT_W'(READ_LATENCY - 1);
               sram_addr_nxt  = cpu_addr;
               sram_wdata_nxt = cpu_wdata;
               sram_sel_nxt   = cpu_sel;
               sram_ren_nxt   = ~cpu_wen;
               sram_wen_nxt   = cpu_wen;
            end
         end
         CPU_ACC: begin
            if (cnt == '0) begin
               state_nxt    = IDLE;
               cpu_done_nxt = 1'b1;
               if (!sram_wen) begin
                  cpu_rdata_nxt = sram_rdata;
               end else if (sram_addr == buf_addr) begin
                  buf_valid_nxt = 1'b0;
               end
               sram_addr_nxt  = '0;
               sram_wdata_nxt = '0;
               sram_sel_nxt   = '0;
               sram_ren_nxt   = 1'b0;
               sram_wen_nxt   = 1'b0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         VGA_ACC: begin
            if (cnt == '0) begin
               // A fill overrides a same-cycle frame invalidation
               state_nxt      = IDLE;
               vga_data_nxt   = sram_rdata;
               buf_addr_nxt   = sram_addr;
               buf_valid_nxt  = 1'b1;
               sram_addr_nxt  = '0;
               sram_wdata_nxt = '0;
               sram_sel_nxt   = '0;
               sram_ren_nxt   = 1'b0;
               sram_wen_nxt   = 1'b0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_request_handler.sv
// Directed self-checking bench for sram_request_handler (READ_LATENCY = 2).
module tb_sram_request_handler;

   logic        clk = 1'b0;
   logic        nrst;
   logic [1:0]  vga_state;
   logic        vga_req;
   logic [31:0] vga_addr;
   logic [31:0] vga_data;
   logic        vga_busy;
   logic        cpu_ren;
   logic        cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_sel;
   logic [31:0] cpu_rdata;
   logic        cpu_busy;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_sel;
   logic        sram_ren;
   logic        sram_wen;
   logic [31:0] sram_rdata;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int ren_cnt  = 0;
   int r0;

   sram_request_handler #(.READ_LATENCY(2), .ADDR_W(32)) dut (
      .clk(clk), .nrst(nrst),
      .vga_state(vga_state), .vga_req(vga_req), .vga_addr(vga_addr),
      .vga_data(vga_data), .vga_busy(vga_busy),
      .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_sel(sram_sel),
      .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // Number of cycles the read strobe was seen high
   always @(negedge clk) if (sram_ren) ren_cnt++;

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      nrst = 1'b0; vga_state = 2'd0; vga_req = 1'b0; vga_addr = '0;
      cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_sel = '0;
      sram_rdata = '0;
      next_cycle(); next_cycle();
      #1;
      chk_cnt++; if (sram_ren !== 1'b0) $display("FAIL rst_sram_ren got %0h want 0", sram_ren); else pass_cnt++;
      chk_cnt++; if (sram_wen !== 1'b0) $display("FAIL rst_sram_wen got %0h want 0", sram_wen); else pass_cnt++;
      chk_cnt++; if (sram_addr !== 32'h0) $display("FAIL rst_sram_addr got %0h want 0", sram_addr); else pass_cnt++;
      chk_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL rst_cpu_rdata got %0h want 0", cpu_rdata); else pass_cnt++;
      chk_cnt++; if (vga_data !== 32'h0) $display("FAIL rst_vga_data got %0h want 0", vga_data); else pass_cnt++;
      vga_req = 1'b1; cpu_ren = 1'b1;
      #1;
      chk_cnt++; if (vga_busy !== 1'b1) $display("FAIL rst_vga_busy got %0h want 1", vga_busy); else pass_cnt++;
      chk_cnt++; if (cpu_busy !== 1'b1) $display("FAIL rst_cpu_busy got %0h want 1", cpu_busy); else pass_cnt++;
      vga_req = 1'b0; cpu_ren = 1'b0;
      next_cycle();
      nrst = 1'b1;
      next_cycle();
   endtask

   task automatic test_cpu_read();
      cpu_ren = 1'b1; cpu_addr = 32'h10; sram_rdata = 32'hDEADBEEF;
      #1;
      chk_cnt++; if (cpu_busy !== 1'b1) $display("FAIL rd_busy_c0 got %0h want 1", cpu_busy); else pass_cnt++;
      chk_cnt++; if (sram_ren !== 1'b0) $display("FAIL rd_ren_c0 got %0h want 0", sram_ren); else pass_cnt++;
      for (int i = 1; i <= 2; i++) begin
         next_cycle(); #1;
         chk_cnt++; if (sram_ren !== 1'b1) $display("FAIL rd_ren_c%0d got %0h want 1", i, sram_ren); else pass_cnt++;
         chk_cnt++; if (sram_addr !== 32'h10) $display("FAIL rd_addr_c%0d got %0h want 10", i, sram_addr); else pass_cnt++;
         chk_cnt++; if (cpu_busy !== 1'b1) $display("FAIL rd_busy_c%0d got %0h want 1", i, cpu_busy); else pass_cnt++;
      end
      next_cycle(); #1;
      chk_cnt++; if (cpu_busy !== 1'b0) $display("FAIL rd_busy_done got %0h want 0", cpu_busy); else pass_cnt++;
      chk_cnt++; if (sram_ren !== 1'b0) $display("FAIL rd_ren_done got %0h want 0", sram_ren); else pass_cnt++;
      chk_cnt++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL rd_data got %0h want deadbeef", cpu_rdata); else pass_cnt++;
      cpu_ren = 1'b0;
      next_cycle(); #1;
      chk_cnt++; if (sram_ren !== 1'b0) $display("FAIL rd_no_reissue got %0h want 0", sram_ren); else pass_cnt++;
   endtask

   task automatic test_vga_miss_hit();
      vga_state = 2'd2; vga_req = 1'b1; vga_addr = 32'h3E80; sram_rdata = 32'h12345678;
      r0 = ren_cnt;
      #1;
      chk_cnt++; if (vga_busy !== 1'b1) $display("FAIL vm_busy_c0 got %0h want 1", vga_busy); else pass_cnt++;
      next_cycle(); #1;
      chk_cnt++; if (sram_sel !== 4'hF) $display("FAIL vm_sel got %0h want f", sram_sel); else pass_cnt++;
      chk_cnt++; if (sram_addr !== 32'h3E80) $display("FAIL vm_addr got %0h want 3e80", sram_addr); else pass_cnt++;
      chk_cnt++; if (sram_wen !== 1'b0) $display("FAIL vm_wen got %0h want 0", sram_wen); else pass_cnt++;
      next_cycle(); #1;
      chk_cnt++; if (vga_busy !== 1'b1) $display("FAIL vm_busy_c2 got %0h want 1", vga_busy); else pass_cnt++;
      next_cycle(); #1;
      chk_cnt++; if (vga_busy !== 1'b0) $display("FAIL vm_busy_c3 got %0h want 0", vga_busy); else pass_cnt++;
      chk_cnt++; if (vga_data !== 32'h12345678) $display("FAIL vm_data got %0h want 12345678", vga_data); else pass_cnt++;
      chk_cnt++; if (ren_cnt - r0 !== 2) $display("FAIL vm_ren_cycles got %0d want 2", ren_cnt - r0); else pass_cnt++;
      r0 = ren_cnt;
      sram_rdata = 32'hFFFF0000;
      repeat (20) next_cycle();
      #1;
      chk_cnt++; if (ren_cnt - r0 !== 0) $display("FAIL vh_no_read got %0d want 0", ren_cnt - r0); else pass_cnt++;
      chk_cnt++; if (vga_busy !== 1'b0) $display("FAIL vh_busy got %0h want 0", vga_busy); else pass_cnt++;
      chk_cnt++; if (vga_data !== 32'h12345678) $display("FAIL vh_data got %0h want 12345678", vga_data); else pass_cnt++;
   endtask

   task automatic test_cpu_stall_write();
      vga_state = 2'd1; vga_req = 1'b0;
      cpu_wen = 1'b1; cpu_ren = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A50F0F; cpu_sel = 4'h5;
      for (int i = 0; i < 5; i++) begin
         next_cycle(); #1;
         chk_cnt++; if (cpu_busy !== 1'b1 || sram_wen !== 1'b0)
            $display("FAIL st_stall_c%0d busy %0h wen %0h want 1 0", i, cpu_busy, sram_wen); else pass_cnt++;
      end
      next_cycle();
      vga_state = 2'd0;
      for (int i = 1; i <= 2; i++) begin
         next_cycle(); #1;
         chk_cnt++; if (sram_wen !== 1'b1 || sram_ren !== 1'b0)
            $display("FAIL st_wen_c%0d wen %0h ren %0h want 1 0", i, sram_wen, sram_ren); else pass_cnt++;
         chk_cnt++; if (sram_wdata !== 32'hA5A50F0F) $display("FAIL st_wdata got %0h want a5a50f0f", sram_wdata); else pass_cnt++;
         chk_cnt++; if (sram_sel !== 4'h5) $display("FAIL st_sel got %0h want 5", sram_sel); else pass_cnt++;
         chk_cnt++; if (sram_addr !== 32'h20) $display("FAIL st_addr got %0h want 20", sram_addr); else pass_cnt++;
      end
      next_cycle(); #1;
      chk_cnt++; if (cpu_busy !== 1'b0 || sram_wen !== 1'b0)
         $display("FAIL st_done busy %0h wen %0h want 0 0", cpu_busy, sram_wen); else pass_cnt++;
      cpu_wen = 1'b0; cpu_ren = 1'b0;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      cpu_ren = 1'b1; cpu_addr = 32'h30; sram_rdata = 32'hCAFEF00D;
      next_cycle();
      vga_req = 1'b1; vga_addr = 32'h4000;
      #1;
      chk_cnt++; if (sram_addr !== 32'h30 || vga_busy !== 1'b1)
         $display("FAIL bb_cpu_first addr %0h vbusy %0h want 30 1", sram_addr, vga_busy); else pass_cnt++;
      next_cycle(); #1;
      chk_cnt++; if (sram_addr !== 32'h30) $display("FAIL bb_cpu_hold got %0h want 30", sram_addr); else pass_cnt++;
      next_cycle(); #1;
      chk_cnt++; if (cpu_busy !== 1'b0 || cpu_rdata !== 32'hCAFEF00D)
         $display("FAIL bb_cpu_done busy %0h data %0h want 0 cafef00d", cpu_busy, cpu_rdata); else pass_cnt++;
      chk_cnt++; if (sram_ren !== 1'b0 || vga_busy !== 1'b1)
         $display("FAIL bb_idle_gap ren %0h vbusy %0h want 0 1", sram_ren, vga_busy); else pass_cnt++;
      cpu_ren = 1'b0; sram_rdata = 32'h0BADC0DE;
      next_cycle(); #1;
      chk_cnt++; if (sram_ren !== 1'b1 || sram_addr !== 32'h4000 || vga_busy !== 1'b1)
         $display("FAIL bb_vga_start ren %0h addr %0h vbusy %0h want 1 4000 1", sram_ren, sram_addr, vga_busy); else pass_cnt++;
      next_cycle(); #1;
      chk_cnt++; if (vga_busy !== 1'b1) $display("FAIL bb_vga_wait got %0h want 1", vga_busy); else pass_cnt++;
      next_cycle(); #1;
      chk_cnt++; if (vga_busy !== 1'b0 || vga_data !== 32'h0BADC0DE)
         $display("FAIL bb_vga_done busy %0h data %0h want 0 badc0de", vga_busy, vga_data); else pass_cnt++;
      vga_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_invalidate();
      vga_req = 1'b1; vga_addr = 32'h3E81; sram_rdata = 32'h11110000;
      repeat (3) next_cycle();
      #1;
      chk_cnt++; if (vga_busy !== 1'b0 || vga_data !== 32'h11110000)
         $display("FAIL inv_fill busy %0h data %0h want 0 11110000", vga_busy, vga_data); else pass_cnt++;
      vga_req = 1'b0;
      cpu_wen = 1'b1; cpu_addr = 32'h3E81; cpu_wdata = 32'h55; cpu_sel = 4'hF;
      repeat (3) next_cycle();
      #1;
      chk_cnt++; if (cpu_busy !== 1'b0) $display("FAIL inv_wr_done got %0h want 0", cpu_busy); else pass_cnt++;
      cpu_wen = 1'b0;
      next_cycle();
      vga_req = 1'b1; sram_rdata = 32'h22220000; r0 = ren_cnt;
      #1;
      chk_cnt++; if (vga_busy !== 1'b1) $display("FAIL inv_wr_miss got %0h want 1", vga_busy); else pass_cnt++;
      repeat (3) next_cycle();
      #1;
      chk_cnt++; if (vga_data !== 32'h22220000 || ren_cnt - r0 !== 2)
         $display("FAIL inv_wr_refetch data %0h reads %0d want 22220000 2", vga_data, ren_cnt - r0); else pass_cnt++;
      vga_req = 1'b0; vga_state = 2'd1;
      next_cycle();
      vga_req = 1'b1; sram_rdata = 32'h33330000;
      #1;
      chk_cnt++; if (vga_busy !== 1'b1) $display("FAIL inv_frame_miss got %0h want 1", vga_busy); else pass_cnt++;
      repeat (3) next_cycle();
      #1;
      chk_cnt++; if (vga_busy !== 1'b0 || vga_data !== 32'h33330000)
         $display("FAIL inv_frame_refill busy %0h data %0h want 0 33330000", vga_busy, vga_data); else pass_cnt++;
   endtask

   task automatic test_reset_mid_access();
      vga_state = 2'd2; vga_addr = 32'h5000; sram_rdata = 32'h44440000;
      next_cycle(); #1;
      chk_cnt++; if (sram_ren !== 1'b1) $display("FAIL ra_ren_before got %0h want 1", sram_ren); else pass_cnt++;
      nrst = 1'b0;
      #1;
      chk_cnt++; if (sram_ren !== 1'b0 || sram_addr !== 32'h0 || sram_sel !== 4'h0)
         $display("FAIL ra_async ren %0h addr %0h sel %0h want 0 0 0", sram_ren, sram_addr, sram_sel); else pass_cnt++;
      vga_addr = 32'h3E81;
      #1;
      chk_cnt++; if (vga_busy !== 1'b1) $display("FAIL ra_buf_cleared got %0h want 1", vga_busy); else pass_cnt++;
      vga_addr = 32'h5000;
      next_cycle();
      nrst = 1'b1;
      #1;
      chk_cnt++; if (vga_busy !== 1'b1) $display("FAIL ra_miss_after got %0h want 1", vga_busy); else pass_cnt++;
      next_cycle(); #1;
      chk_cnt++; if (sram_ren !== 1'b1 || sram_addr !== 32'h5000)
         $display("FAIL ra_refetch ren %0h addr %0h want 1 5000", sram_ren, sram_addr); else pass_cnt++;
      repeat (2) next_cycle();
      #1;
      chk_cnt++; if (vga_busy !== 1'b0 || vga_data !== 32'h44440000)
         $display("FAIL ra_refill busy %0h data %0h want 0 44440000", vga_busy, vga_data); else pass_cnt++;
      vga_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_vga_miss_hit();
      test_cpu_stall_write();
      test_back_to_back();
      test_invalidate();
      test_reset_mid_access();
      repeat (2) next_cycle();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
